// File: rtl/pixel_plot_queue.sv
// pixel_plot_queue: pixel sink FIFO with off-screen clipping and a stallable framebuffer write port.
// Defining PIXEL_QUEUE_CLEAR_EN adds clear/bg_colour and a full-screen background sweep.
module pixel_plot_queue #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120,
  parameter int unsigned CW         = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          plot,
  input  logic [7:0]    x,
  input  logic [6:0]    y,
  input  logic [CW-1:0] colour,
`ifdef PIXEL_QUEUE_CLEAR_EN
  input  logic          clear,
  input  logic [CW-1:0] bg_colour,
`endif
  output logic          full,
  output logic          overflow,
  output logic [7:0]    clipped,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [14:0]   mem_addr,
  output logic [CW-1:0] mem_data,
  output logic          idle
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = 15;
  localparam int unsigned EW    = AW + CW;
  localparam logic [8:0]    X_LIM = 9'(H_RES);
  localparam logic [7:0]    Y_LIM = 8'(V_RES);
  localparam logic [AW-1:0] H_MUL = AW'(H_RES);

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          in_range;
  logic          stage_load;
  logic          pop;
  logic          accept;
  logic          bypass;
  logic          push;
  logic          blocked;
  logic [AW-1:0] pix_addr;
  logic [EW-1:0] head;
  logic          sweep_on;
  logic [AW-1:0] sweep_cnt;
  logic [CW-1:0] sweep_colour;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign in_range   = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  // 160 = 128 + 32, so the default geometry needs no multiplier
  assign pix_addr   = (H_RES == 160) ?
                      (({8'b0, y} << 7) + ({8'b0, y} << 5) + {7'b0, x}) :
                      (AW'(y) * H_MUL + AW'(x));
  assign head       = fifo_mem[rd_ptr[PW-2:0]];

  assign stage_load = ~mem_we | mem_ready;
  assign pop        = stage_load & ~fifo_empty;
  // a pop in the same cycle frees a slot, so a full queue can still accept
  assign accept     = plot & in_range & ~blocked & (~fifo_full | pop);
  assign bypass     = accept & fifo_empty & stage_load;
  assign push       = accept & ~bypass;

  assign idle = fifo_empty & ~mem_we & ~sweep_on;
  assign full = fifo_full | sweep_on;

`ifdef PIXEL_QUEUE_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);
  logic sweep_go;

  assign sweep_go = clear & idle;
  assign blocked  = sweep_on | sweep_go;

  // Background sweep address generator; advances once per accepted write slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_on     <= 1'b0;
      sweep_cnt    <= '0;
      sweep_colour <= '0;
    end else if (sweep_go) begin
      sweep_on     <= 1'b1;
      sweep_cnt    <= '0;
      sweep_colour <= bg_colour;
    end else if (sweep_on && stage_load) begin
      if (sweep_cnt == LAST_ADDR) sweep_on <= 1'b0;
      sweep_cnt <= sweep_cnt + AW'(1);
    end
  end
`else
  assign sweep_on     = 1'b0;
  assign sweep_cnt    = '0;
  assign sweep_colour = '0;
  assign blocked      = 1'b0;
`endif

  // Pointers, status flags and the one-entry output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      clipped  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (plot && in_range && !accept && !blocked) overflow <= 1'b1;
      if (plot && !in_range && clipped != 8'hFF) clipped <= clipped + 8'd1;
      if (stage_load) begin
        if (sweep_on) begin
          mem_we   <= 1'b1;
          mem_addr <= sweep_cnt;
          mem_data <= sweep_colour;
        end else if (pop) begin
          mem_we                <= 1'b1;
          {mem_addr, mem_data}  <= head;
        end else if (bypass) begin
          mem_we   <= 1'b1;
          mem_addr <= pix_addr;
          mem_data <= colour;
        end else begin
          mem_we   <= 1'b0;
        end
      end
    end
  end

  // Queue storage holds no reset state; pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-2:0]] <= {pix_addr, colour};
  end

endmodule

// File: tb/tb_pixel_plot_queue.sv
// tb_pixel_plot_queue: randomized self-checking bench for pixel_plot_queue against an occupancy/queue model.
`timescale 1ns/1ps
module tb_pixel_plot_queue;
  localparam int CW  = 24;
  localparam int H   = 160;
  localparam int V   = 120;
  localparam int CAP = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          plot = 1'b0;
  logic [7:0]    x = '0;
  logic [6:0]    y = '0;
  logic [CW-1:0] colour = '0;
  logic          full;
  logic          overflow;
  logic [7:0]    clipped;
  logic          mem_ready = 1'b0;
  logic          mem_we;
  logic [14:0]   mem_addr;
  logic [CW-1:0] mem_data;
  logic          idle;
`ifdef PIXEL_QUEUE_CLEAR_EN
  logic          clear = 1'b0;
  logic [CW-1:0] bg_colour = '0;
`endif

  pixel_plot_queue dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
`ifdef PIXEL_QUEUE_CLEAR_EN
    .clear(clear), .bg_colour(bg_colour),
`endif
    .full(full), .overflow(overflow), .clipped(clipped), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: items in flight (stage + queue), capacity DEPTH+1, with accepted/observed write lists
  int          m_pend;
  bit          m_ovf;
  int          m_clip;
  logic [38:0] acc_q[$];
  logic [38:0] wr_q[$];

  function automatic void model_reset();
    m_pend = 0; m_ovf = 0; m_clip = 0;
    acc_q.delete(); wr_q.delete();
  endfunction

  task automatic step(input logic p, input logic [7:0] px, input logic [6:0] py,
                      input logic [CW-1:0] pc, input logic rdy);
    plot = p; x = px; y = py; colour = pc; mem_ready = rdy;
    #1;
    if (mem_we && mem_ready) wr_q.push_back({mem_addr, mem_data});
    if (m_pend > 0 && rdy) m_pend--;
    if (p) begin
      if (int'(px) >= H || int'(py) >= V) begin
        if (m_clip < 255) m_clip++;
      end else if (m_pend < CAP) begin
        m_pend++;
        acc_q.push_back({15'(int'(py) * H + int'(px)), pc});
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    plot = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_data !== 24'd0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", mem_data); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (clipped !== 8'd0) begin errors++; $display("FAIL reset_clipped got %0d exp 0", clipped); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [38:0] w;
    do_reset();
    step(1'b1, 8'd3, 7'd2, 24'hFF0000, 1'b1);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", mem_we); end
    checks++; if (mem_addr !== 15'd323) begin errors++; $display("FAIL single_addr got %0d exp 323", mem_addr); end
    checks++; if (mem_data !== 24'hFF0000) begin errors++; $display("FAIL single_data got %h exp ff0000", mem_data); end
    step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle); end
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", wr_q.size()); end
    w = (wr_q.size() > 0) ? wr_q[0] : 'x;
    checks++; if (w !== {15'd323, 24'hFF0000}) begin errors++; $display("FAIL single_write got %h exp %h", w, {15'd323, 24'hFF0000}); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i * 7), 7'(i * 3), CW'($urandom), 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL fill_we got %b exp 1", mem_we); end
    for (int i = 0; i < 12; i++) step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (wr_q.size() != 9) begin errors++; $display("FAIL fill_count got %0d exp 9", wr_q.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      logic [38:0] w;
      w = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (w !== acc_q[i]) begin errors++; $display("FAIL fill_order[%0d] got %h exp %h", i, w, acc_q[i]); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fill_idle got %b exp 1", idle); end
  endtask

  task automatic test_clip();
    do_reset();
    step(1'b1, 8'd160, 7'd0, 24'h123456, 1'b1);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clip_we_x got %b exp 0", mem_we); end
    step(1'b1, 8'd0, 7'd120, 24'h654321, 1'b1);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clip_we_y got %b exp 0", mem_we); end
    step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (clipped !== 8'd2) begin errors++; $display("FAIL clip_count got %0d exp 2", clipped); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clip_overflow got %b exp 0", overflow); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL clip_writes got %0d exp 0", wr_q.size()); end
    for (int i = 0; i < 260; i++) step(1'b1, 8'd200, 7'd5, '0, 1'b1);
    checks++; if (clipped !== 8'd255) begin errors++; $display("FAIL clip_saturate got %0d exp 255", clipped); end
  endtask

  task automatic test_full_push();
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(10 + i), 7'(100 + i), CW'($urandom), 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full got %b exp 1", full); end
    step(1'b1, 8'd159, 7'd119, 24'hABCDEF, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b exp 0", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_still_full got %b exp 1", full); end
    for (int i = 0; i < 12; i++) step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (wr_q.size() != 10) begin errors++; $display("FAIL fp_count got %0d exp 10", wr_q.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      logic [38:0] w;
      w = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (w !== acc_q[i]) begin errors++; $display("FAIL fp_order[%0d] got %h exp %h", i, w, acc_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 7'(i), CW'($urandom), 1'b0);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmid_we_before got %b exp 1", mem_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we_async got %b exp 0", mem_we); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b exp 1", idle); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL rmid_writes got %0d exp 0", wr_q.size()); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we_after got %b exp 0", mem_we); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      rdy = (i < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      step($urandom_range(0, 9) < 7, 8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)),
           CW'($urandom), rdy);
      checks++; if (mem_we !== (m_pend > 0) || full !== (m_pend == CAP) || idle !== (m_pend == 0)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rand_status cyc %0d got we=%b full=%b idle=%b exp pend=%0d", i, mem_we, full, idle, m_pend);
      end
    end
    for (int i = 0; i < 15; i++) step(1'b0, 8'd0, 7'd0, '0, 1'b1);
    checks++; if (wr_q.size() != acc_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", wr_q.size(), acc_q.size()); end
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      logic [38:0] w;
      w = (i < wr_q.size()) ? wr_q[i] : 'x;
      checks++; if (w !== acc_q[i]) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rand_order[%0d] got %h exp %h", i, w, acc_q[i]);
      end
    end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow got %b exp %b", overflow, m_ovf); end
    checks++; if (clipped !== 8'(m_clip)) begin errors++; $display("FAIL rand_clipped got %0d exp %0d", clipped, m_clip); end
  endtask

`ifdef PIXEL_QUEUE_CLEAR_EN
  task automatic test_clear();
    int cnt = 0;
    int bad = 0;
    int last = -1;
    do_reset();
    mem_ready = 1'b1; bg_colour = 24'h000000; clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checks++; if (full !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL clr_busy got full=%b idle=%b exp 1/0", full, idle); end
    for (int i = 0; i < 25000 && !idle; i++) begin
      if (mem_we) begin
        cnt++; last = int'(mem_addr);
        if (mem_data !== 24'h000000) bad++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (cnt != H * V) begin errors++; $display("FAIL clr_count got %0d exp %0d", cnt, H * V); end
    checks++; if (last != H * V - 1) begin errors++; $display("FAIL clr_last got %0d exp %0d", last, H * V - 1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_data got %0d bad exp 0", bad); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL clr_idle got %b exp 1", idle); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_clip();
    test_full_push();
    test_reset_mid();
    test_random();
`ifdef PIXEL_QUEUE_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
